// File: rtl/core_alu_issue.sv
// Issue stage ahead of core_alu: decodes OP/OP-IMM/LUI/AUIPC and builds the ALU opcode and operands.
// It strobes the ALU, then hands the result to writeback. ALU_ISSUE_BYPASS_EN adds WB->EXEC overlap and forwarding.
module core_alu_issue #(
   parameter int XLEN          = 32,
   parameter int RST_PC_UNUSED = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ID_VALID,
   output logic        ID_READY,
   input  logic [31:0] ID_INSTR,
   input  logic [31:0] ID_PC,
   input  logic [31:0] RS1_DATA,
   input  logic [31:0] RS2_DATA,
   output logic        C_ALU,
   output logic [9:0]  OPCODE_ALU,
   output logic [31:0] ALU_I1,
   output logic [31:0] ALU_I2,
   input  logic [31:0] ALU_O,
   output logic        WB_VALID,
   input  logic        WB_READY,
   output logic [4:0]  WB_RD,
   output logic [31:0] WB_DATA,
   output logic        ILLEGAL
);

   // state  | meaning
   // S_IDLE | waiting for an instruction from decode
   // S_EXEC | ALU capture strobe asserted for this one cycle
   // S_WB   | result offered to the register file until WB_READY
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [9:0] ALU_CODE_SUM = 10'b0000000_000;

   if (XLEN != 32 || RST_PC_UNUSED != 0) begin : g_bad_param
      $error("core_alu_issue supports only XLEN=32 and RST_PC_UNUSED=0");
   end

   logic [1:0]  state;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        dec_legal;
   logic [9:0]  dec_op;
   logic [31:0] dec_i1;
   logic [31:0] dec_i2;
   logic        accept;

   assign opc = ID_INSTR[6:0];
   assign f3  = ID_INSTR[14:12];
   assign f7  = ID_INSTR[31:25];

   assign C_ALU    = (state == S_EXEC);
   assign WB_VALID = (state == S_WB);
   assign WB_DATA  = WB_VALID ? ALU_O : 32'd0;

`ifdef ALU_ISSUE_BYPASS_EN
   logic [4:0] rs1;
   logic [4:0] rs2;
   assign rs1 = ID_INSTR[19:15];
   assign rs2 = ID_INSTR[24:20];
   // Only an accept in S_WB can see a pending result, so forwarding is gated by WB_VALID.
   assign rs1_val  = (WB_VALID && rs1 != 5'd0 && rs1 == WB_RD) ? WB_DATA : RS1_DATA;
   assign rs2_val  = (WB_VALID && rs2 != 5'd0 && rs2 == WB_RD) ? WB_DATA : RS2_DATA;
   assign ID_READY = ~RST & ((state == S_IDLE) | ((state == S_WB) & WB_READY));
`else
   assign rs1_val  = RS1_DATA;
   assign rs2_val  = RS2_DATA;
   assign ID_READY = ~RST & (state == S_IDLE);
`endif

   assign accept = ID_VALID & ID_READY;

   always_comb begin
      dec_legal = 1'b0;
      dec_op    = ALU_CODE_SUM;
      dec_i1    = 32'd0;
      dec_i2    = 32'd0;
      case (opc)
         OPC_OP: begin
            dec_i1 = rs1_val;
            dec_i2 = rs2_val;
            dec_op = {f7, f3};
            // The ALU shifts by all of I2, so trim to the 5-bit shift amount.
            if (f3 == 3'b001 || f3 == 3'b101) dec_i2 = {27'd0, rs2_val[4:0]};
            if (f7 == 7'd0) dec_legal = 1'b1;
            else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) dec_legal = 1'b1;
         end
         OPC_OPIMM: begin
            dec_i1    = rs1_val;
            dec_i2    = {{20{ID_INSTR[31]}}, ID_INSTR[31:20]};
            dec_op    = {7'd0, f3};
            dec_legal = 1'b1;
            if (f3 == 3'b001) begin
               dec_i2    = {27'd0, ID_INSTR[24:20]};
               dec_legal = (f7 == 7'd0);
            end else if (f3 == 3'b101) begin
               dec_i2    = {27'd0, ID_INSTR[24:20]};
               dec_legal = (f7 == 7'd0) || (f7 == F7_ALT);
               if (f7 == F7_ALT) dec_op = {F7_ALT, f3};
            end
         end
         OPC_LUI: begin
            dec_legal = 1'b1;
            dec_i2    = {ID_INSTR[31:12], 12'd0};
         end
         OPC_AUIPC: begin
            dec_legal = 1'b1;
            dec_i1    = ID_PC;
            dec_i2    = {ID_INSTR[31:12], 12'd0};
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         OPCODE_ALU <= 10'd0;
         ALU_I1     <= 32'd0;
         ALU_I2     <= 32'd0;
         WB_RD      <= 5'd0;
         ILLEGAL    <= 1'b0;
      end else begin
         ILLEGAL <= accept & ~dec_legal;
         if (accept && dec_legal) begin
            state      <= S_EXEC;
            OPCODE_ALU <= dec_op;
            ALU_I1     <= dec_i1;
            ALU_I2     <= dec_i2;
            WB_RD      <= ID_INSTR[11:7];
         end else begin
            case (state)
               S_EXEC:  state <= S_WB;
               S_WB:    if (WB_READY) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/core_alu_issue.md
Name: core_alu_issue

Overview:
Issue/sequencing stage directly upstream of core_alu in the RV32I core. It accepts one decoded instruction plus register-file read data over a valid/ready handshake, and builds the ALU opcode and operands. It pulses C_ALU for one cycle, then presents the ALU result to register-file writeback over a second valid/ready handshake. It covers OP, OP-IMM, LUI and AUIPC.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RST_PC_UNUSED, 0, reserved; must stay 0.

Ports:
CLK  in  1  core clock, rising edge.
RST  in  1  asynchronous reset, active-high.
ID_VALID  in  1  instruction and operands valid.
ID_READY  out  1  stage can accept an instruction.
ID_INSTR  in  32  raw instruction word.
ID_PC  in  32  PC of ID_INSTR.
RS1_DATA  in  32  register-file value of rs1 (ID_INSTR[19:15]).
RS2_DATA  in  32  register-file value of rs2 (ID_INSTR[24:20]).
C_ALU  out  1  ALU capture enable.
OPCODE_ALU  out  10  {funct7, funct3}, matching the `ALU_CODE_* defines in define.vh.
ALU_I1  out  32  ALU operand 1.
ALU_I2  out  32  ALU operand 2.
ALU_O  in  32  registered ALU result.
WB_VALID  out  1  writeback request.
WB_READY  in  1  register file takes the write.
WB_RD  out  5  destination register.
WB_DATA  out  32  writeback value.
ILLEGAL  out  1  one-cycle pulse on an unsupported instruction.

Behaviour:
- Interface fixed: one clock CLK; RST is asynchronous and active-high. While RST is high:
  - state = IDLE; C_ALU, OPCODE_ALU, ALU_I1, ALU_I2, WB_VALID, WB_RD and ILLEGAL are all 0; ID_READY = 0.
- States: IDLE, EXEC, WB. ID_READY = (state == IDLE).
- IDLE, when ID_VALID & ID_READY at a rising edge:
  - Legal instruction: register OPCODE_ALU, ALU_I1, ALU_I2 and WB_RD = instr[11:7]; go to EXEC.
  - Illegal instruction: the instruction is consumed, ILLEGAL = 1 for exactly one cycle, state stays IDLE.
- EXEC: C_ALU = 1 for exactly one cycle; next state WB. ALU_O is valid from the following cycle.
- WB:
  - WB_VALID = 1, WB_DATA = ALU_O.
  - Hold while WB_READY = 0. ALU_O is stable because C_ALU = 0.
  - On WB_READY go to IDLE; WB_VALID drops the next cycle.
  - Outside WB, WB_DATA = 0.
- Latency: accept edge E0, C_ALU high during cycle E0–E1, WB_VALID high from E1. Throughput is 1 instruction per 3 cycles.
- Operand and opcode formation:
  - OP (0110011): I1 = RS1_DATA, I2 = RS2_DATA, OPCODE = {instr[31:25], instr[14:12]}.
  - OP-IMM (0010011): I1 = RS1_DATA, I2 = sign-extended instr[31:20]. funct7 is forced to 0 except for SRAI, where it is 0100000.
  - LUI (0110111): I1 = 0, I2 = {instr[31:12], 12'b0}, OPCODE = `ALU_CODE_SUM.
  - AUIPC (0010111): I1 = ID_PC, I2 = U-immediate, OPCODE = `ALU_CODE_SUM.
- Shifts (SLL/SRL/SRA, register or immediate): I2 = {27'b0, shamt[4:0]}, because the ALU shifts by the full I2.
- Illegal cases:
  - Any other major opcode.
  - OP funct7 not in {0000000, 0100000}.
  - OP funct7 = 0100000 with funct3 other than ADD/SRL.
  - OP-IMM shift with instr[31:25] not in {0000000, 0100000}.
  - SLLI with instr[30] set.
- rd = x0: the writeback handshake still occurs with WB_RD = 0; the register file discards it.
- ID_VALID while not in IDLE: ignored, not consumed.
- Reset in EXEC or WB: the pending writeback is dropped and no WB_VALID follows.

Optional Feature:
ALU_ISSUE_BYPASS_EN.
- Defined:
  - In WB, ID_READY = WB_READY. A simultaneous WB handshake and ID accept goes directly WB -> EXEC, giving 2-cycle throughput.
  - Forwarding: if rs1 (or rs2) is non-zero and equals WB_RD, WB_DATA replaces RS1_DATA (or RS2_DATA).
- Undefined: ID_READY only in IDLE, no forwarding, 3-cycle throughput.

Test Plan:
- ADD x3,x1,x2 with RS1 = 5, RS2 = 7 -> OPCODE = `ALU_CODE_SUM, C_ALU high exactly 1 cycle, WB_VALID next cycle with WB_RD = 3, WB_DATA = 12.
- SUB with RS1 = 0, RS2 = 1 -> WB_DATA = 0xFFFFFFFF. SRAI shamt 4 on 0x80000000 -> 0xF8000000.
- SLL with RS2 = 0x21, RS1 = 1 -> ALU_I2 = 1, WB_DATA = 2. ADDI with imm = -1 (instr[30] set) -> OPCODE = SUM, not SUB.
- LUI 0x12345 -> 0x12345000. AUIPC imm 1 at PC = 0x100 -> 0x1100. Opcode 0000011 -> ILLEGAL pulse for 1 cycle, no C_ALU, no WB_VALID.
- WB_READY held low 5 cycles -> WB_VALID and WB_DATA stable, ID_READY = 0. RST asserted in WB -> all outputs 0 immediately, no writeback after release.
- With ALU_ISSUE_BYPASS_EN: ADDI x1,x0,9 then ADD x2,x1,x1 back-to-back, RS1_DATA stale = 0 -> WB_DATA = 18, 2 cycles between the WB handshakes.
